bus_src_mux: RTL

Parametrised, registered source-select unit that drives the processor data bus from one of NUM_SRC datapath registers (N, M, P, R, ROW, COL, CURR, SUM, STA/STB/STC, A, B, R1 in the base configuration). It sits between the datapath register file and the bus/accumulator write port and is controlled by the control unit. Unlike the previous single-cycle combinational select, it accepts a request handshake and can stream a burst of consecutive sources, one word per cycle. It also supports stall, select-error reporting and a registered output.

---
 rtl/bus_src_mux_pkg.sv | 19 +
 rtl/bus_src_mux_sel.sv | 25 ++
 rtl/bus_src_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/bus_src_mux_pkg.sv
// bus_src_mux_pkg: shared types and helpers for the bus source-select unit.
//   state_t   - transfer FSM states (IDLE, XFER)
//   SEL_NONE  - select code reported when no source word is on the bus
//   next_sel  - successor of a source code, wrapping n -> 1
package bus_src_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int unsigned SEL_NONE = 0;

  // Source codes run 1..n, so the successor of n is 1 (code 0 is never a source).
  function automatic int unsigned next_sel(input int unsigned x, input int unsigned n);
    return (x >= n) ? 32'd1 : x + 32'd1;
  endfunction

endpackage

// File: rtl/bus_src_mux_sel.sv
// bus_src_sel: combinational extraction of one DATA_W source word from the
// flattened source vector.
//   src_flat - NUM_SRC words; code i lives at bits [i*DATA_W-1 : (i-1)*DATA_W]
//   code     - source code; 0 or > NUM_SRC selects nothing
//   data     - selected word, 0 for an invalid code
module bus_src_sel #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 14,
  parameter int SEL_W   = 4
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  input  logic [SEL_W-1:0]          code,
  output logic [DATA_W-1:0]         data
);

  always_comb begin
    data = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (code == SEL_W'(i)) begin
        data = src_flat[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/bus_src_mux.sv
// bus_src_mux: registered, handshaked source select driving the data bus from
// one of NUM_SRC datapath registers, with burst streaming over consecutive
// source codes (wrapping NUM_SRC -> 1), stall, and select-error reporting.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   src_flat   - flattened sources, code i at bits [i*DATA_W-1 : (i-1)*DATA_W]
//   req/sel/len- transfer request, first source code, burst length (0 = 1)
//   stall      - freezes an in-progress burst / defers acceptance in IDLE
//   dout       - registered bus word; dout_valid marks transfer words
//   busy       - burst in progress (further requests ignored)
//   sel_err    - one-cycle pulse for a request with an invalid select code
//   cur_sel    - source code of the word on dout, 0 when not valid
// Build option: BUS_SRC_MUX_HOLD_EN keeps the last word on dout while idle;
// otherwise dout reads 0 whenever dout_valid is low.
module bus_src_mux
  import bus_src_mux_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int NUM_SRC = 14,
  localparam int SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  input  logic                      req,
  input  logic [SEL_W-1:0]          sel,
  input  logic [SEL_W-1:0]          len,
  input  logic                      stall,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      sel_err,
  output logic [SEL_W-1:0]          cur_sel
);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   remaining;
  logic [SEL_W-1:0]   code;
  logic [SEL_W-1:0]   next_code;
  logic [SEL_W-1:0]   len_eff;
  logic [DATA_W-1:0]  word;
  logic               sel_ok;
  logic               accept;
  logic               issue;

  // One extractor serves both phases: the request code in IDLE, the running
  // pointer in XFER.
  always_comb begin
    sel_ok    = (sel != '0) && (32'(sel) <= 32'(NUM_SRC));
    len_eff   = (len == '0) ? SEL_W'(1) : len;
    accept    = (state == IDLE) && req && !stall && sel_ok;
    issue     = accept || ((state == XFER) && !stall);
    code      = (state == IDLE) ? sel : ptr;
    next_code = SEL_W'(next_sel(32'(code), NUM_SRC));
  end

  bus_src_sel #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_sel (
    .src_flat (src_flat),
    .code     (code),
    .data     (word)
  );

  assign busy = (state == XFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
      cur_sel    <= SEL_W'(SEL_NONE);
    end else begin
      sel_err    <= (state == IDLE) && req && !sel_ok;
      dout_valid <= issue;
      cur_sel    <= issue ? code : SEL_W'(SEL_NONE);
`ifdef BUS_SRC_MUX_HOLD_EN
      if (issue) dout <= word;
`else
      dout <= issue ? word : '0;
`endif
      if (issue) ptr <= next_code;

      // remaining counts words still to issue after the one going out now.
      if (accept) begin
        remaining <= len_eff - SEL_W'(1);
        if (len_eff != SEL_W'(1)) state <= XFER;
      end else if ((state == XFER) && !stall) begin
        remaining <= remaining - SEL_W'(1);
        if (remaining == SEL_W'(1)) state <= IDLE;
      end
    end
  end

endmodule
